if_fetch: RTL and testbench



---
 rtl/if_fetch.sv | 140 ++++++++++++++
 tb/tb_if_fetch.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction fetch unit: owns the fetch PC, issues in-order word requests and queues returned words for decode.
// Optional macro IF_MISALIGN_CHK_EN: a misaligned redirect target pulses if_misalign_o and halts fetch.
module if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 4,
  parameter int          CNT_W      = 3
) (
  input  logic        clk,
  input  logic        rst,
  output logic        if_mem_req_o,
  output logic [31:0] if_mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        fc_bk_if_i,
  input  logic        id_jump_flag_i,
  input  logic [31:0] id_jump_pc_i,
  input  logic        ex_btype_flag_i,
  input  logic [31:0] ex_btype_pc_i,
  output logic [31:0] if_inst_o,
  output logic [31:0] if_pc_o,
  output logic        if_inst_valid_o,
  output logic        if_misalign_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // Handshakes: a request is accepted in the cycle req_o && gnt_i, and req_o/addr_o never change
  // while waiting for gnt_i. Decode takes the head in the cycle valid_o && !fc_bk_if_i.
  logic [31:0]      pc_mem_q   [FIFO_DEPTH];
  logic [31:0]      inst_mem_q [FIFO_DEPTH];
  logic [PW-1:0]    head_q, tail_q, fill_q;
  logic [PW-1:0]    head_d, tail_d, fill_d;
  logic [CNT_W-1:0] occ_q, nfill_q, discard_q;
  logic [CNT_W-1:0] occ_d, nfill_d, discard_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d, addr_q, addr_d;
  logic             req_q, req_d, stale_q, stale_d, halt_q, halt_d, misalign_q, misalign_d;

  logic             redirect, tgt_bad, granted, alloc, fill, drop, consume, valid;
  logic [31:0]      raw_tgt, tgt;
  logic [CNT_W-1:0] unfilled;

  always_comb begin
    redirect = ex_btype_flag_i | id_jump_flag_i;
    raw_tgt  = ex_btype_flag_i ? ex_btype_pc_i : id_jump_pc_i;
`ifdef IF_MISALIGN_CHK_EN
    tgt      = raw_tgt;
    tgt_bad  = (raw_tgt[1:0] != 2'b00);
`else
    tgt      = raw_tgt & ~32'h3;
    tgt_bad  = 1'b0;
`endif
    granted  = req_q & mem_gnt_i;
    // A grant for a request issued before a redirect carries no queue entry.
    alloc    = granted & ~stale_q & ~redirect;
    unfilled = occ_q - nfill_q;
    drop     = mem_rvalid_i & (discard_q != '0);
    fill     = mem_rvalid_i & (discard_q == '0) & (unfilled != '0) & ~redirect;
    valid    = (nfill_q != '0);
    consume  = valid & ~fc_bk_if_i & ~redirect;

    occ_d      = occ_q + CNT_W'(alloc) - CNT_W'(consume);
    nfill_d    = nfill_q + CNT_W'(fill) - CNT_W'(consume);
    head_d     = head_q + PW'(consume);
    tail_d     = tail_q + PW'(alloc);
    fill_d     = fill_q + PW'(fill);
    discard_d  = discard_q - CNT_W'(drop) + CNT_W'(granted & stale_q);
    fetch_pc_d = alloc ? (fetch_pc_q + 32'd4) : fetch_pc_q;
    halt_d     = halt_q;
    misalign_d = 1'b0;

    if (redirect) begin
      occ_d      = '0;
      nfill_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      fill_d     = '0;
      // Every response still owed by memory must be thrown away.
      discard_d  = discard_q + unfilled + CNT_W'(granted) - CNT_W'(mem_rvalid_i);
      fetch_pc_d = tgt;
      halt_d     = tgt_bad;
      misalign_d = tgt_bad;
    end

    if (req_q && !mem_gnt_i) begin
      req_d   = 1'b1;
      addr_d  = addr_q;
      stale_d = stale_q | redirect;
    end else begin
      req_d   = (occ_d < DEPTH_C) & ~halt_d;
      addr_d  = fetch_pc_d;
      stale_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      stale_q    <= 1'b0;
      halt_q     <= 1'b0;
      misalign_q <= 1'b0;
      occ_q      <= '0;
      nfill_q    <= '0;
      discard_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
    end else begin
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      stale_q    <= stale_d;
      halt_q     <= halt_d;
      misalign_q <= misalign_d;
      occ_q      <= occ_d;
      nfill_q    <= nfill_d;
      discard_q  <= discard_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
    end
  end

  // Payload storage needs no reset: the counters decide what is visible.
  always_ff @(posedge clk) begin
    if (alloc) pc_mem_q[tail_q] <= addr_q;
    if (fill) inst_mem_q[fill_q] <= mem_rdata_i;
  end

  assign if_mem_req_o    = req_q;
  assign if_mem_addr_o   = addr_q;
  assign if_inst_valid_o = valid;
  assign if_inst_o       = valid ? inst_mem_q[head_q] : 32'h0;
  assign if_pc_o         = valid ? pc_mem_q[head_q] : 32'h0;
  assign if_misalign_o   = misalign_q;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: in-order memory model plus a PC-stream scoreboard.
module tb_if_fetch;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk, rst;
  logic        if_mem_req_o, mem_gnt_i, mem_rvalid_i;
  logic [31:0] if_mem_addr_o, mem_rdata_i;
  logic        fc_bk_if_i, id_jump_flag_i, ex_btype_flag_i;
  logic [31:0] id_jump_pc_i, ex_btype_pc_i;
  logic [31:0] if_inst_o, if_pc_o;
  logic        if_inst_valid_o, if_misalign_o;

  if_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .if_mem_req_o(if_mem_req_o), .if_mem_addr_o(if_mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .fc_bk_if_i(fc_bk_if_i),
    .id_jump_flag_i(id_jump_flag_i), .id_jump_pc_i(id_jump_pc_i),
    .ex_btype_flag_i(ex_btype_flag_i), .ex_btype_pc_i(ex_btype_pc_i),
    .if_inst_o(if_inst_o), .if_pc_o(if_pc_o),
    .if_inst_valid_o(if_inst_valid_o), .if_misalign_o(if_misalign_o)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } mem_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          consumed = 0;
  int          gnt_pct  = 100;
  int          lat      = 1;
  bit          rand_lat = 1'b0;
  mem_t        mem_q[$];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h0000_0013 + a;
  endfunction

  // Decode must see a sequential PC stream from the last redirect target.
  function automatic void refill(input logic [31:0] start);
    exp_q.delete();
    for (int k = 0; k < 64; k++) exp_q.push_back(start + 32'(4 * k));
  endfunction

  // One cycle: memory model drives its inputs, scoreboard checks, then advance to next negedge.
  task automatic tick();
    logic        g, rv, redir;
    logic [31:0] rd, tgt;
    g  = 1'b0;
    rv = 1'b0;
    rd = $urandom;
    if (rst) mem_q.delete();
    else begin
      if (mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
        rv = 1'b1;
        rd = word_at(mem_q[0].addr);
      end
      g = (if_mem_req_o === 1'b1) && ($urandom_range(1, 100) <= gnt_pct);
    end
    mem_gnt_i    = g;
    mem_rvalid_i = rv;
    mem_rdata_i  = rd;
    redir = ex_btype_flag_i || id_jump_flag_i;
    if (rst) refill(RESET_PC);
    else begin
      n_checks++;
      if (if_inst_valid_o !== 1'b1 && (if_inst_o !== 32'h0 || if_pc_o !== 32'h0)) begin
        n_fail++;
        $display("FAIL bubble_zero: cycle %0d inst=%h pc=%h required 0", cyc, if_inst_o, if_pc_o);
      end
      if (!redir && if_inst_valid_o === 1'b1 && !fc_bk_if_i) begin
        n_checks++;
        consumed++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL consume_unexpected: cycle %0d pc=%h required no instruction", cyc, if_pc_o);
        end else begin
          if (if_pc_o !== exp_q[0] || if_inst_o !== word_at(exp_q[0])) begin
            n_fail++;
            $display("FAIL consume: cycle %0d pc=%h inst=%h required pc=%h inst=%h",
                     cyc, if_pc_o, if_inst_o, exp_q[0], word_at(exp_q[0]));
          end
          exp_q.push_back(exp_q[$] + 32'd4);
          void'(exp_q.pop_front());
        end
      end
      if (redir) begin
        tgt = ex_btype_flag_i ? ex_btype_pc_i : id_jump_pc_i;
`ifdef IF_MISALIGN_CHK_EN
        if (tgt[1:0] != 2'b00) exp_q.delete();
        else refill(tgt);
`else
        refill(tgt & ~32'h3);
`endif
      end
      if (rv) void'(mem_q.pop_front());
      if (g) mem_q.push_back('{addr: if_mem_addr_o, ready: cyc + (rand_lat ? $urandom_range(1, 3) : lat)});
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fc_bk_if_i = 1'b0; id_jump_flag_i = 1'b0; ex_btype_flag_i = 1'b0;
    tick();
    n_checks += 6;
    if (if_mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b required 0", if_mem_req_o); end
    if (if_mem_addr_o !== RESET_PC) begin n_fail++; $display("FAIL reset_addr: got %h required %h", if_mem_addr_o, RESET_PC); end
    if (if_inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", if_inst_valid_o); end
    if (if_inst_o !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h required 0", if_inst_o); end
    if (if_pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h required 0", if_pc_o); end
    if (if_misalign_o !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b required 0", if_misalign_o); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_stream();
    int first_g, first_v, gaps, c0;
    logic [31:0] exp_addr;
    first_g = -1; first_v = -1; gaps = 0; c0 = consumed; exp_addr = RESET_PC;
    gnt_pct = 100; lat = 1; rand_lat = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (if_mem_req_o === 1'b1) begin
        if (first_g < 0) first_g = i;
        n_checks++;
        if (if_mem_addr_o !== exp_addr) begin
          n_fail++;
          $display("FAIL stream_addr: step %0d addr=%h required %h", i, if_mem_addr_o, exp_addr);
        end
        exp_addr += 32'd4;
      end
      if (if_inst_valid_o === 1'b1 && first_v < 0) first_v = i;
      else if (first_v >= 0 && if_inst_valid_o !== 1'b1) gaps++;
      tick();
    end
    n_checks += 3;
    if (first_g < 0 || first_v - first_g != 2) begin
      n_fail++; $display("FAIL stream_latency: grant->valid=%0d required 2", first_v - first_g);
    end
    if (gaps != 0) begin n_fail++; $display("FAIL stream_gaps: got %0d required 0", gaps); end
    if (consumed - c0 != 30 - first_v) begin
      n_fail++; $display("FAIL stream_count: got %0d required %0d", consumed - c0, 30 - first_v);
    end
  endtask

  task automatic test_hold();
    logic [31:0] i0, p0;
    int c0;
    n_checks++;
    if (if_inst_valid_o !== 1'b1) begin n_fail++; $display("FAIL hold_start_valid: got %b required 1", if_inst_valid_o); end
    i0 = if_inst_o; p0 = if_pc_o;
    fc_bk_if_i = 1'b1;
    tick();
    for (int i = 1; i < 5; i++) begin
      n_checks++;
      if (if_inst_valid_o !== 1'b1 || if_inst_o !== i0 || if_pc_o !== p0) begin
        n_fail++;
        $display("FAIL hold_frozen: step %0d valid=%b inst=%h pc=%h required 1 %h %h", i, if_inst_valid_o, if_inst_o, if_pc_o, i0, p0);
      end
      if (i >= 2) begin
        n_checks++;
        if (if_mem_req_o !== 1'b0) begin n_fail++; $display("FAIL hold_full_req: step %0d req=%b required 0", i, if_mem_req_o); end
      end
      tick();
    end
    fc_bk_if_i = 1'b0;
    c0 = consumed;
    repeat (10) tick();
    n_checks++;
    if (consumed - c0 != 10) begin n_fail++; $display("FAIL hold_release_count: got %0d required 10", consumed - c0); end
  endtask

  task automatic test_jump();
    int k;
    lat = 2;
    repeat (10) tick();
    id_jump_flag_i = 1'b1; id_jump_pc_i = 32'h100;
    tick();
    id_jump_flag_i = 1'b0;
    n_checks += 2;
    if (if_inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL jump_valid_r1: got %b required 0", if_inst_valid_o); end
    if (if_mem_req_o !== 1'b1 || if_mem_addr_o !== 32'h100) begin
      n_fail++; $display("FAIL jump_req_r1: req=%b addr=%h required 1 00000100", if_mem_req_o, if_mem_addr_o);
    end
    k = 0;
    while (if_inst_valid_o !== 1'b1 && k < 12) begin tick(); k++; end
    n_checks++;
    if (if_inst_valid_o !== 1'b1 || if_pc_o !== 32'h100 || k < 2) begin
      n_fail++; $display("FAIL jump_first: valid=%b pc=%h after %0d required 1 00000100 after >=2", if_inst_valid_o, if_pc_o, k);
    end
    lat = 1;
    repeat (6) tick();
  endtask

  task automatic test_branch_priority();
    int k;
    ex_btype_flag_i = 1'b1; ex_btype_pc_i = 32'h200;
    id_jump_flag_i  = 1'b1; id_jump_pc_i  = 32'h300;
    tick();
    ex_btype_flag_i = 1'b0; id_jump_flag_i = 1'b0;
    n_checks++;
    if (if_mem_req_o !== 1'b1 || if_mem_addr_o !== 32'h200) begin
      n_fail++; $display("FAIL prio_req: req=%b addr=%h required 1 00000200", if_mem_req_o, if_mem_addr_o);
    end
    k = 0;
    while (if_inst_valid_o !== 1'b1 && k < 12) begin tick(); k++; end
    n_checks++;
    if (if_inst_valid_o !== 1'b1 || if_pc_o !== 32'h200) begin
      n_fail++; $display("FAIL prio_first: valid=%b pc=%h required 1 00000200", if_inst_valid_o, if_pc_o);
    end
    repeat (4) tick();
  endtask

  task automatic test_pending_redirect();
    logic [31:0] a;
    int k;
    gnt_pct = 0;
    repeat (6) tick();
    n_checks++;
    if (if_mem_req_o !== 1'b1) begin n_fail++; $display("FAIL pend_req_before: got %b required 1", if_mem_req_o); end
    a = if_mem_addr_o;
    id_jump_flag_i = 1'b1; id_jump_pc_i = 32'h400;
    tick();
    id_jump_flag_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) gnt_pct = 100;
      n_checks++;
      if (if_mem_req_o !== 1'b1 || if_mem_addr_o !== a) begin
        n_fail++; $display("FAIL pend_hold: step %0d req=%b addr=%h required 1 %h", i, if_mem_req_o, if_mem_addr_o, a);
      end
      tick();
    end
    n_checks++;
    if (if_mem_req_o !== 1'b1 || if_mem_addr_o !== 32'h400) begin
      n_fail++; $display("FAIL pend_new_req: req=%b addr=%h required 1 00000400", if_mem_req_o, if_mem_addr_o);
    end
    k = 0;
    while (if_inst_valid_o !== 1'b1 && k < 12) begin tick(); k++; end
    n_checks++;
    if (if_inst_valid_o !== 1'b1 || if_pc_o !== 32'h400) begin
      n_fail++; $display("FAIL pend_first: valid=%b pc=%h required 1 00000400", if_inst_valid_o, if_pc_o);
    end
    repeat (4) tick();
  endtask

  task automatic test_misalign();
    int k;
    id_jump_flag_i = 1'b1; id_jump_pc_i = 32'h102;
    tick();
    id_jump_flag_i = 1'b0;
`ifdef IF_MISALIGN_CHK_EN
    n_checks++;
    if (if_misalign_o !== 1'b1) begin n_fail++; $display("FAIL mis_pulse: got %b required 1", if_misalign_o); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (if_misalign_o !== 1'b0 || if_mem_req_o !== 1'b0) begin
        n_fail++; $display("FAIL mis_halt: step %0d misalign=%b req=%b required 0 0", i, if_misalign_o, if_mem_req_o);
      end
    end
    id_jump_flag_i = 1'b1; id_jump_pc_i = 32'h104;
    tick();
    id_jump_flag_i = 1'b0;
    n_checks++;
    if (if_mem_req_o !== 1'b1 || if_mem_addr_o !== 32'h104) begin
      n_fail++; $display("FAIL mis_resume: req=%b addr=%h required 1 00000104", if_mem_req_o, if_mem_addr_o);
    end
    k = 0;
    while (if_inst_valid_o !== 1'b1 && k < 12) begin tick(); k++; end
    n_checks++;
    if (if_inst_valid_o !== 1'b1 || if_pc_o !== 32'h104) begin
      n_fail++; $display("FAIL mis_first: valid=%b pc=%h required 1 00000104", if_inst_valid_o, if_pc_o);
    end
`else
    n_checks++;
    if (if_misalign_o !== 1'b0 || if_mem_req_o !== 1'b1 || if_mem_addr_o !== 32'h100) begin
      n_fail++; $display("FAIL mis_force: misalign=%b req=%b addr=%h required 0 1 00000100", if_misalign_o, if_mem_req_o, if_mem_addr_o);
    end
    k = 0;
    while (if_inst_valid_o !== 1'b1 && k < 12) begin tick(); k++; end
    n_checks++;
    if (if_inst_valid_o !== 1'b1 || if_pc_o !== 32'h100) begin
      n_fail++; $display("FAIL mis_first: valid=%b pc=%h required 1 00000100", if_inst_valid_o, if_pc_o);
    end
`endif
    repeat (4) tick();
  endtask

  task automatic test_random();
    int c0, r;
    c0 = consumed;
    gnt_pct = 60; rand_lat = 1'b1;
    repeat (400) begin
      r = $urandom_range(0, 99);
      fc_bk_if_i      = ($urandom_range(0, 99) < 30);
      id_jump_flag_i  = (r < 4);
      ex_btype_flag_i = (r >= 2 && r < 6);
      id_jump_pc_i    = 32'h1000 + 32'($urandom_range(0, 255) * 4);
      ex_btype_pc_i   = 32'h2000 + 32'($urandom_range(0, 255) * 4);
      tick();
    end
    fc_bk_if_i = 1'b0; id_jump_flag_i = 1'b0; ex_btype_flag_i = 1'b0;
    gnt_pct = 100; rand_lat = 1'b0; lat = 1;
    repeat (12) tick();
    n_checks++;
    if (consumed - c0 < 40) begin n_fail++; $display("FAIL random_progress: got %0d required >=40", consumed - c0); end
  endtask

  task automatic test_restart();
    int c0;
    c0 = consumed;
    repeat (12) tick();
    n_checks++;
    if (consumed - c0 != 9) begin n_fail++; $display("FAIL restart_count: got %0d required 9", consumed - c0); end
  endtask

  initial begin
    rst = 1'b1;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    fc_bk_if_i = 1'b0; id_jump_flag_i = 1'b0; ex_btype_flag_i = 1'b0;
    id_jump_pc_i = 32'h0; ex_btype_pc_i = 32'h0;
    refill(RESET_PC);
    @(negedge clk);
    test_reset();
    test_stream();
    test_hold();
    test_jump();
    test_branch_priority();
    test_pending_redirect();
    test_misalign();
    test_random();
    gnt_pct = 70; rand_lat = 1'b1;
    repeat (5) tick();
    test_reset();
    gnt_pct = 100; rand_lat = 1'b0; lat = 1;
    test_restart();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
